// File: rtl/frog_game_ctrl_pkg.sv
// Shared encodings and constants for the frogger game-sequencing controller.
package frog_pkg;

  localparam int unsigned ROW_W   = 3;
  localparam int unsigned COL_W   = 8;
  localparam int unsigned LIVES_W = 3;
  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PLAY = 3'd1;
  localparam logic [2:0] ST_HIT  = 3'd2;
  localparam logic [2:0] ST_WIN  = 3'd3;
  localparam logic [2:0] ST_OVER = 3'd4;

  localparam logic [ROW_W-1:0]   FROG_START_ROW = 3'd7;
  localparam logic [COL_W-1:0]   FROG_START_COL = 8'b0001_0000;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX      = 2'd3;

  // Occupancy of the row the frog is on; rows 0, 4 and 7 carry no traffic.
  function automatic logic [COL_W-1:0] row_occ(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] l1, input logic [COL_W-1:0] l2,
    input logic [COL_W-1:0] l3, input logic [COL_W-1:0] l5,
    input logic [COL_W-1:0] l6);
    case (row)
      3'd1:    row_occ = l1;
      3'd2:    row_occ = l2;
      3'd3:    row_occ = l3;
      3'd5:    row_occ = l5;
      3'd6:    row_occ = l6;
      default: row_occ = '0;
    endcase
  endfunction

endpackage

// File: rtl/frog_game_ctrl_if.sv
// Board-side bundle: buttons and lane occupancy in, frog/lane-step/status out.
interface frog_game_ctrl_if;
  import frog_pkg::*;

  logic               btn_up_n;
  logic               btn_down_n;
  logic               btn_left_n;
  logic               btn_right_n;
  logic               btn_start_n;
  logic [COL_W-1:0]   lane1;
  logic [COL_W-1:0]   lane2;
  logic [COL_W-1:0]   lane3;
  logic [COL_W-1:0]   lane5;
  logic [COL_W-1:0]   lane6;
  logic               lane_step;
  logic [ROW_W-1:0]   frog_row;
  logic [COL_W-1:0]   frog_col;
  logic [LIVES_W-1:0] lives;
  logic [LEVEL_W-1:0] level;
  logic [STATE_W-1:0] state;

  modport master (
    input  btn_up_n, btn_down_n, btn_left_n, btn_right_n, btn_start_n,
    input  lane1, lane2, lane3, lane5, lane6,
    output lane_step, frog_row, frog_col, lives, level, state
  );

  modport slave (
    output btn_up_n, btn_down_n, btn_left_n, btn_right_n, btn_start_n,
    output lane1, lane2, lane3, lane5, lane6,
    input  lane_step, frog_row, frog_col, lives, level, state
  );
endinterface

// File: rtl/frog_game_ctrl_btn_edge_sync.sv
// Two-flop synchronizer for an active-low button plus a one-cycle press pulse
// on each synchronized 1->0 transition.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);

  logic meta_q, sync_q, prev_q, press_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      meta_q  <= btn_n_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      press_q <= prev_q & ~sync_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/frog_game_ctrl.sv
// Frogger game sequencer: frog position, lives, level, lane-step timing and
// collision/goal detection.
module frog_game_ctrl
  import frog_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned START_LIVES = 3
) (
  input  logic             clk,
  input  logic             reset,
  frog_game_ctrl_if.master bus
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic up_ev, down_ev, left_ev, right_ev, start_ev;

  btn_edge_sync u_up    (.clk(clk), .rst_n(reset), .btn_n_i(bus.btn_up_n),    .press_o(up_ev));
  btn_edge_sync u_down  (.clk(clk), .rst_n(reset), .btn_n_i(bus.btn_down_n),  .press_o(down_ev));
  btn_edge_sync u_left  (.clk(clk), .rst_n(reset), .btn_n_i(bus.btn_left_n),  .press_o(left_ev));
  btn_edge_sync u_right (.clk(clk), .rst_n(reset), .btn_n_i(bus.btn_right_n), .press_o(right_ev));
  btn_edge_sync u_start (.clk(clk), .rst_n(reset), .btn_n_i(bus.btn_start_n), .press_o(start_ev));

  logic [STATE_W-1:0] state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               step_q, step_d;

  logic coll_c, tick_last_c, hold_last_c;

  assign coll_c = (row_occ(row_q, bus.lane1, bus.lane2, bus.lane3, bus.lane5, bus.lane6)
                   & col_q) != '0;
  // Lane period halves with each level.
  assign tick_last_c = tick_q == TICK_W'((TICK_DIV >> level_q) - 1);
  assign hold_last_c = hold_q == HOLD_W'(HOLD_CYCLES - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      row_q   <= FROG_START_ROW;
      col_q   <= FROG_START_COL;
      lives_q <= LIVES_W'(START_LIVES);
      level_q <= '0;
      tick_q  <= '0;
      hold_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lives_q <= lives_d;
      level_q <= level_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lives_d = lives_q;
    level_d = level_q;
    tick_d  = tick_q;
    hold_d  = hold_q;
    step_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          state_d = ST_PLAY;
          tick_d  = '0;
        end
      end
      ST_PLAY: begin
        if (coll_c) begin
          state_d = ST_HIT;
          lives_d = (lives_q != '0) ? lives_q - 3'd1 : '0;
          hold_d  = '0;
        end else if (row_q == '0) begin
          state_d = ST_WIN;
          level_d = (level_q != LEVEL_MAX) ? level_q + 2'd1 : LEVEL_MAX;
          hold_d  = '0;
        end else begin
          if (tick_last_c) begin
            step_d = 1'b1;
            tick_d = '0;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
          // Move priority: up > down > right > left.
          if (up_ev) begin
            if (row_q != '0) row_d = row_q - 3'd1;
          end else if (down_ev) begin
            if (row_q != FROG_START_ROW) row_d = row_q + 3'd1;
          end else if (right_ev) begin
            if (!col_q[0]) col_d = col_q >> 1;
          end else if (left_ev) begin
            if (!col_q[COL_W-1]) col_d = col_q << 1;
          end
        end
      end
      ST_HIT, ST_WIN: begin
        if (hold_last_c) begin
          hold_d = '0;
          if (state_q == ST_HIT && lives_q == '0) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_PLAY;
            row_d   = FROG_START_ROW;
            col_d   = FROG_START_COL;
            tick_d  = '0;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_OVER: begin
        if (start_ev) begin
          state_d = ST_PLAY;
          lives_d = LIVES_W'(START_LIVES);
          level_d = '0;
          row_d   = FROG_START_ROW;
          col_d   = FROG_START_COL;
          tick_d  = '0;
          hold_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The goal row carries no traffic, so collision and win never coincide.
  assert property (@(posedge clk) disable iff (!reset)
                   !(state_q == ST_PLAY && coll_c && row_q == '0));

  assign bus.lane_step = step_q;
  assign bus.frog_row  = row_q;
  assign bus.frog_col  = col_q;
  assign bus.lives     = lives_q;
  assign bus.level     = level_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl with short tick/hold periods.
module tb_frog_game_ctrl;
  import frog_pkg::*;

  localparam logic [4:0] B_UP = 5'b10000;
  localparam logic [4:0] B_DN = 5'b01000;
  localparam logic [4:0] B_RT = 5'b00100;
  localparam logic [4:0] B_LT = 5'b00010;
  localparam logic [4:0] B_ST = 5'b00001;
  localparam logic [4:0] B_NONE = 5'b00000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  frog_game_ctrl_if bus ();

  frog_game_ctrl #(.TICK_DIV(8), .HOLD_CYCLES(4), .START_LIVES(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] btn;
    int         hold;
    logic [2:0] row;
    logic [7:0] col;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [4:0] m);
    bus.btn_up_n    = ~m[4];
    bus.btn_down_n  = ~m[3];
    bus.btn_right_n = ~m[2];
    bus.btn_left_n  = ~m[1];
    bus.btn_start_n = ~m[0];
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    set_btn(m);
    repeat (hold) @(negedge clk);
    set_btn(B_NONE);
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (bus.state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.state), 32'(s));
  endtask

  // Cycles between two consecutive lane_step pulses.
  task automatic measure_period(input int exp, input string name);
    int  n = 0;
    bit  seen = 0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (bus.lane_step === 1'b1) seen = 1;
    end
    chk({name, "_first"}, 32'(seen), 32'd1);
    n = 0;
    seen = 0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (bus.lane_step === 1'b1) seen = 1;
    end
    chk(name, seen ? n : 0, exp);
  endtask

  // Drive the frog up into a car waiting on row 6; returns once HIT is seen.
  task automatic hit_once(input string name);
    bus.lane6 = 8'h10;
    set_btn(B_UP);
    wait_state(ST_HIT, 20, name);
    set_btn(B_NONE);
    bus.lane6 = 8'h00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 32'(ST_IDLE));
    chk({tag, "_row"},   32'(bus.frog_row), 32'd7);
    chk({tag, "_col"},   32'(bus.frog_col), 32'h10);
    chk({tag, "_lives"}, 32'(bus.lives), 32'd3);
    chk({tag, "_level"}, 32'(bus.level), 32'd0);
    chk({tag, "_step"},  32'(bus.lane_step), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  quiet;

    vecs[0]  = '{B_UP,        20, 3'd6, 8'h10, ST_PLAY};
    vecs[1]  = '{B_RT,         3, 3'd6, 8'h08, ST_PLAY};
    vecs[2]  = '{B_RT,         3, 3'd6, 8'h04, ST_PLAY};
    vecs[3]  = '{B_RT,         3, 3'd6, 8'h02, ST_PLAY};
    vecs[4]  = '{B_RT,         3, 3'd6, 8'h01, ST_PLAY};
    vecs[5]  = '{B_RT,         3, 3'd6, 8'h01, ST_PLAY};
    vecs[6]  = '{B_LT,         3, 3'd6, 8'h02, ST_PLAY};
    vecs[7]  = '{B_UP | B_LT,  3, 3'd5, 8'h02, ST_PLAY};
    vecs[8]  = '{B_DN | B_RT,  3, 3'd6, 8'h02, ST_PLAY};
    vecs[9]  = '{B_DN,         3, 3'd7, 8'h02, ST_PLAY};
    vecs[10] = '{B_DN,         3, 3'd7, 8'h02, ST_PLAY};
    vecs[11] = '{B_ST,         3, 3'd7, 8'h02, ST_PLAY};
    vecs[12] = '{B_LT,         3, 3'd7, 8'h04, ST_PLAY};
    vecs[13] = '{B_LT,         3, 3'd7, 8'h08, ST_PLAY};
    vecs[14] = '{B_LT,         3, 3'd7, 8'h10, ST_PLAY};
    vecs[15] = '{B_LT,         3, 3'd7, 8'h20, ST_PLAY};
    vecs[16] = '{B_LT,         3, 3'd7, 8'h40, ST_PLAY};
    vecs[17] = '{B_LT,         3, 3'd7, 8'h80, ST_PLAY};
    vecs[18] = '{B_LT,         3, 3'd7, 8'h80, ST_PLAY};
    vecs[19] = '{B_RT | B_LT,  3, 3'd7, 8'h40, ST_PLAY};
    vecs[20] = '{B_RT,         3, 3'd7, 8'h20, ST_PLAY};
    vecs[21] = '{B_RT,         3, 3'd7, 8'h10, ST_PLAY};

    reset = 1'b0;
    set_btn(B_NONE);
    bus.lane1 = '0; bus.lane2 = '0; bus.lane3 = '0; bus.lane5 = '0; bus.lane6 = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;

    // IDLE ignores moves and keeps the tick frozen.
    press(B_UP, 3);
    chk("idle_row", 32'(bus.frog_row), 32'd7);
    chk("idle_state", 32'(bus.state), 32'(ST_IDLE));

    press(B_ST, 3);
    chk("start_state", 32'(bus.state), 32'(ST_PLAY));
    measure_period(8, "period_l0");

    for (int i = 0; i < 22; i++) begin
      press(vecs[i].btn, vecs[i].hold);
      chk($sformatf("vec%0d_row", i),   32'(bus.frog_row), 32'(vecs[i].row));
      chk($sformatf("vec%0d_col", i),   32'(bus.frog_col), 32'(vecs[i].col));
      chk($sformatf("vec%0d_state", i), 32'(bus.state),    32'(vecs[i].st));
    end

    // Collision on row 6, then a 4-cycle HIT hold with no lane steps.
    bus.lane6 = 8'h10;
    set_btn(B_UP);
    n = 0;
    while (bus.frog_row !== 3'd6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hit_row6", 32'(bus.frog_row), 32'd6);
    chk("hit_pre_state", 32'(bus.state), 32'(ST_PLAY));
    set_btn(B_NONE);
    @(negedge clk);
    chk("hit_state", 32'(bus.state), 32'(ST_HIT));
    chk("hit_lives", 32'(bus.lives), 32'd2);
    quiet = (bus.lane_step === 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.lane_step !== 1'b0 || bus.state !== ST_HIT) quiet = 0;
    end
    chk("hit_hold_quiet", 32'(quiet), 32'd1);
    @(negedge clk);
    chk("hit_exit_state", 32'(bus.state), 32'(ST_PLAY));
    chk("hit_exit_row", 32'(bus.frog_row), 32'd7);
    chk("hit_exit_col", 32'(bus.frog_col), 32'h10);
    bus.lane6 = 8'h00;

    // Reach the goal row: WIN, level 1, then faster lane steps.
    for (int i = 0; i < 6; i++) press(B_UP, 3);
    chk("win_row1", 32'(bus.frog_row), 32'd1);
    set_btn(B_UP);
    wait_state(ST_WIN, 20, "win_state");
    chk("win_row0", 32'(bus.frog_row), 32'd0);
    chk("win_level", 32'(bus.level), 32'd1);
    chk("win_lives", 32'(bus.lives), 32'd2);
    set_btn(B_NONE);
    wait_state(ST_PLAY, 20, "win_exit_state");
    chk("win_exit_row", 32'(bus.frog_row), 32'd7);
    chk("win_exit_col", 32'(bus.frog_col), 32'h10);
    measure_period(4, "period_l1");

    // Two more collisions exhaust the lives.
    hit_once("over_hit1");
    chk("over_lives1", 32'(bus.lives), 32'd1);
    wait_state(ST_PLAY, 20, "over_resume");
    hit_once("over_hit2");
    chk("over_lives0", 32'(bus.lives), 32'd0);
    wait_state(ST_OVER, 20, "over_state");
    quiet = 1;
    set_btn(B_UP);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.lane_step !== 1'b0 || bus.state !== ST_OVER) quiet = 0;
    end
    set_btn(B_NONE);
    chk("over_frozen", 32'(quiet), 32'd1);
    press(B_ST, 3);
    chk("restart_state", 32'(bus.state), 32'(ST_PLAY));
    chk("restart_lives", 32'(bus.lives), 32'd3);
    chk("restart_level", 32'(bus.level), 32'd0);
    chk("restart_row", 32'(bus.frog_row), 32'd7);
    chk("restart_col", 32'(bus.frog_col), 32'h10);

    // Asynchronous reset in the middle of a HIT hold.
    hit_once("mid_hit");
    chk("mid_hit_lives", 32'(bus.lives), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_state", 32'(bus.state), 32'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
